// File: rtl/sipo_receiver_pkg.sv
// Shared definitions for the serial-in parallel-out receiver.
//   SIPO_N      : default word width
//   clog2       : counter width helper, ceil(log2(v)), minimum 1
//   sipo_n_valid: word-width sanity check, used at elaboration
package sipo_pkg;

  localparam int unsigned SIPO_N = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < v) w++;
    return w;
  endfunction

  function automatic bit sipo_n_valid(input int unsigned n);
    return n >= 2;
  endfunction

endpackage

// File: rtl/sipo_receiver_if.sv
// Parallel-side handshake bundle of the SIPO receiver.
//   q       : completed word
//   valid   : q holds an unconsumed word
//   overrun : sticky word-dropped flag
//   ack     : consumer accepts q
// master = receiver, slave = downstream consumer.
interface sipo_receiver_if
  import sipo_pkg::*;
#(
  parameter int unsigned N = SIPO_N
) ();

  logic [N-1:0] q;
  logic         valid;
  logic         overrun;
  logic         ack;

  modport master (output q, output valid, output overrun, input ack);
  modport slave  (input q, input valid, input overrun, output ack);

endinterface

// File: rtl/sipo_receiver_bit_counter.sv
// Bit position counter for the SIPO receiver.
//   clk, rst : clock, synchronous active-high reset
//   inc      : one bit accepted this edge
//   sync     : restart the word; the accompanying bit (if inc) is bit 0
//   cnt      : bits collected in the current word (0..N-1)
//   last_bit : cnt == N-1, the next accepted bit completes the word
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int unsigned N  = SIPO_N,
  parameter int unsigned CW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          sync,
  output logic [CW-1:0] cnt,
  output logic          last_bit
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (sync) begin
      // The sync-edge bit is bit 0 of the new word.
      cnt <= inc ? CW'(1) : '0;
    end else if (inc) begin
      cnt <= last_bit ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_receiver.sv
// Serial-in parallel-out receiver, MSB first, with valid/ack holding
// register and sticky overrun detection.
//   clk, rst : clock, synchronous active-high reset
//   sin      : serial data, sampled when shift=1
//   shift    : accept one bit this edge
//   sync     : frame resync, current bit becomes bit 0 of a new word
//   bit_cnt  : bits collected in the current word
//   bus      : q / valid / overrun / ack handshake (master side)
module sipo_receiver
  import sipo_pkg::*;
#(
  parameter int unsigned N  = SIPO_N,
  parameter int unsigned CW = clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sin,
  input  logic                   shift,
  input  logic                   sync,
  output logic [CW-1:0]          bit_cnt,
  sipo_receiver_if.master        bus
);

  if (!sipo_n_valid(N)) begin : g_bad_n
    $error("sipo_receiver: N must be >= 2");
  end

  logic [N-1:0] sr;
  logic [N-1:0] candidate;
  logic         last_bit;
  logic         complete;

  sipo_bit_counter #(
    .N  (N),
    .CW (CW)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (shift),
    .sync     (sync),
    .cnt      (bit_cnt),
    .last_bit (last_bit)
  );

  assign candidate = {sr[N-2:0], sin};
  // sync zeroes the count, so with N>=2 a sync edge never completes a word.
  assign complete  = shift && last_bit && !sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr          <= '0;
      bus.q       <= '0;
      bus.valid   <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (sync) begin
        sr <= shift ? {{(N-1){1'b0}}, sin} : '0;
      end else if (shift) begin
        sr <= candidate;
      end

      if (complete) begin
        if (!bus.valid || bus.ack) begin
          bus.q     <= candidate;
          bus.valid <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.valid && bus.ack) begin
        bus.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_receiver.sv
module tb_sipo_receiver;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst;
  logic          sin;
  logic          shift;
  logic          sync;
  logic [CW-1:0] bit_cnt;

  int n_checks;
  int n_fail;

  sipo_receiver_if #(.N(N)) bus ();

  sipo_receiver #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sin     (sin),
    .shift   (shift),
    .sync    (sync),
    .bit_cnt (bit_cnt),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic s, input logic sh, input logic sy, input logic a);
    sin     = s;
    shift   = sh;
    sync    = sy;
    bus.ack = a;
    @(posedge clk);
    #1;
    sin     = 1'b0;
    shift   = 1'b0;
    sync    = 1'b0;
    bus.ack = 1'b0;
  endtask

  task automatic send(input logic b);
    step(b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [3:0] eq, input logic ev,
                             input logic eo, input logic [1:0] ec);
    check({tag, ".q"},       32'(bus.q),       32'(eq));
    check({tag, ".valid"},   32'(bus.valid),   32'(ev));
    check({tag, ".overrun"}, 32'(bus.overrun), 32'(eo));
    check({tag, ".bit_cnt"}, 32'(bit_cnt),     32'(ec));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; sin = 1'b0; shift = 1'b0; sync = 1'b0; bus.ack = 1'b0;
    @(posedge clk); #1;
    do_reset();
    check_state("reset", 4'h0, 1'b0, 1'b0, 2'd0);

    // Basic word 1011
    send(1); send(0); send(1);
    check_state("w1_3bits", 4'h0, 1'b0, 1'b0, 2'd3);
    send(1);
    check_state("w1_done", 4'hB, 1'b1, 1'b0, 2'd0);

    // Ack with no shift
    step(0, 0, 0, 1);
    check_state("ack1", 4'hB, 1'b0, 1'b0, 2'd0);
    step(0, 0, 0, 1);
    check_state("ack_idle", 4'hB, 1'b0, 1'b0, 2'd0);

    // Overrun: 1011 pending, 0110 dropped
    send(1); send(0); send(1); send(1);
    check_state("ov_pend", 4'hB, 1'b1, 1'b0, 2'd0);
    send(0); send(1); send(1); send(0);
    check_state("ov_drop", 4'hB, 1'b1, 1'b1, 2'd0);
    step(0, 0, 0, 1);
    check_state("ov_ack", 4'hB, 1'b0, 1'b1, 2'd0);
    do_reset();
    check_state("ov_rst", 4'h0, 1'b0, 1'b0, 2'd0);

    // Completion with simultaneous ack replaces the word
    send(1); send(0); send(1); send(1);
    send(0); send(0); send(0);
    check_state("ackc_pre", 4'hB, 1'b1, 1'b0, 2'd3);
    step(1, 1, 0, 1);
    check_state("ackc_done", 4'h1, 1'b1, 1'b0, 2'd0);

    // sync while valid leaves the handshake alone
    step(0, 0, 1, 0);
    check_state("sync_valid", 4'h1, 1'b1, 1'b0, 2'd0);
    step(0, 0, 0, 1);
    check_state("ackc_clr", 4'h1, 1'b0, 1'b0, 2'd0);

    // Resync mid-word: 1,1 discarded, sync+0 then 1,0,1 -> 0101
    send(1); send(1);
    check_state("rs_part", 4'h1, 1'b0, 1'b0, 2'd2);
    step(0, 1, 1, 0);
    check_state("rs_sync", 4'h1, 1'b0, 1'b0, 2'd1);
    send(1); send(0);
    check_state("rs_3", 4'h1, 1'b0, 1'b0, 2'd3);
    send(1);
    check_state("rs_done", 4'h5, 1'b1, 1'b0, 2'd0);
    step(0, 0, 0, 1);

    // sync without shift zeroes the count
    send(1); send(1);
    step(0, 0, 1, 0);
    check_state("sync_noshift", 4'h5, 1'b0, 1'b0, 2'd0);

    // Gaps between bits: 1001
    send(1); step(0, 0, 0, 0);
    send(0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    check_state("gap_hold", 4'h5, 1'b0, 1'b0, 2'd2);
    send(0); step(0, 0, 0, 0);
    send(1);
    check_state("gap_done", 4'h9, 1'b1, 1'b0, 2'd0);
    step(0, 0, 0, 1);

    // Reset mid-word then 1111
    send(1); send(0); send(1);
    do_reset();
    check_state("mid_rst", 4'h0, 1'b0, 1'b0, 2'd0);
    send(1); send(1); send(1);
    check_state("post_rst3", 4'h0, 1'b0, 1'b0, 2'd3);
    send(1);
    check_state("post_rst4", 4'hF, 1'b1, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
